// File: rtl/trap_ctrl_pkg.sv
// Shared trap/CSR definitions: cause codes, interrupt codes, CSR update kinds,
// privilege levels and the trap controller state encoding.
package trap_ctrl_pkg;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [4:0] EXC_INSN_MISALIGN = 5'd0;
    localparam logic [4:0] EXC_ILLEGAL_INSN  = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT    = 5'd3;
    localparam logic [4:0] EXC_ECALL_U       = 5'd8;
    localparam logic [4:0] EXC_ECALL_S       = 5'd9;
    localparam logic [4:0] EXC_ECALL_M       = 5'd11;

    typedef enum logic [4:0] {
        IRQ_SSI = 5'd1,
        IRQ_MSI = 5'd3,
        IRQ_STI = 5'd5,
        IRQ_MTI = 5'd7,
        IRQ_SEI = 5'd9,
        IRQ_MEI = 5'd11
    } irq_code_e;

    typedef enum logic [1:0] {
        KIND_TRAP_M = 2'd0,
        KIND_TRAP_S = 2'd1,
        KIND_MRET   = 2'd2,
        KIND_SRET   = 2'd3
    } csr_kind_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Fetch redirect handshake between the trap controller (master) and fetch (slave).
// Signals: redir_valid, redir_pc (master->slave), redir_ready (slave->master).
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready;

    modport master (
        output redir_valid,
        output redir_pc,
        input  redir_ready
    );

    modport slave (
        input  redir_valid,
        input  redir_pc,
        output redir_ready
    );
endinterface

// File: rtl/trap_ctrl_int_prio.sv
// trap_int_prio: combinational interrupt selection with delegation and enables.
// In: mip/mie/mideleg, cur_mode, mstatus_mie/sie. Out: valid, code, to-S target.
module trap_int_prio
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mip,
    input  logic [XLEN-1:0] i_mie,
    input  logic [XLEN-1:0] i_mideleg,
    input  logic [1:0]      i_cur_mode,
    input  logic            i_mstatus_mie,
    input  logic            i_mstatus_sie,
    output logic            o_valid,
    output logic [4:0]      o_code,
    output logic            o_to_s
);
    logic [XLEN-1:0] w_pend;
    logic [XLEN-1:0] w_m_set;
    logic [XLEN-1:0] w_s_set;
    logic            w_m_en;
    logic            w_s_en;
    logic            w_m_hit;
    logic            w_s_hit;
    logic [4:0]      w_m_code;
    logic [4:0]      w_s_code;

    // Fixed architectural order, highest first.
    function automatic logic [5:0] pick(input logic [XLEN-1:0] s);
        if (s[11])     return {1'b1, IRQ_MEI};
        else if (s[3]) return {1'b1, IRQ_MSI};
        else if (s[7]) return {1'b1, IRQ_MTI};
        else if (s[9]) return {1'b1, IRQ_SEI};
        else if (s[1]) return {1'b1, IRQ_SSI};
        else if (s[5]) return {1'b1, IRQ_STI};
        else           return 6'd0;
    endfunction

    assign w_pend  = i_mip & i_mie;
    assign w_m_set = w_pend & ~i_mideleg;
    assign w_s_set = w_pend & i_mideleg;
    assign w_m_en  = (i_cur_mode != PRIV_M) || i_mstatus_mie;
    assign w_s_en  = (i_cur_mode == PRIV_U) ||
                     ((i_cur_mode == PRIV_S) && i_mstatus_sie);

    assign {w_m_hit, w_m_code} = w_m_en ? pick(w_m_set) : 6'd0;
    assign {w_s_hit, w_s_code} = w_s_en ? pick(w_s_set) : 6'd0;

    // Any enabled M-targeted interrupt beats every S-targeted one.
    assign o_valid = w_m_hit || w_s_hit;
    assign o_code  = w_m_hit ? w_m_code : w_s_code;
    assign o_to_s  = !w_m_hit && w_s_hit;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: turns commit exceptions, interrupts and xRET into CSR updates and a
// fetch redirect; stalls commit until fetch accepts. Optional macro: TRAP_VECTORED_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter bit PRIO_INT_OVER_EXC = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmt_valid,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic            cmt_exc,
    input  logic [4:0]      cmt_ecode,
    input  logic [XLEN-1:0] cmt_tval,
    input  logic            cmt_mret,
    input  logic            cmt_sret,
    input  logic [1:0]      cur_mode,
    input  logic            mstatus_mie,
    input  logic            mstatus_sie,
    input  logic [XLEN-1:0] mip,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] medeleg,
    input  logic [XLEN-1:0] mideleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    output logic            cmt_stall,
    output logic            csr_we,
    output logic [1:0]      csr_kind,
    output logic [XLEN-1:0] csr_cause,
    output logic [XLEN-1:0] csr_epc,
    output logic [XLEN-1:0] csr_tval,
    trap_ctrl_if.master     fetch
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("trap_ctrl: XLEN must be 32 or 64");
    end

    trap_state_e     r_state;
    trap_state_e     w_next;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_irq_valid;
    logic [4:0]      w_irq_code;
    logic            w_irq_to_s;
    logic            w_ret_both;
    logic            w_exc_any;
    logic [4:0]      w_exc_code;
    logic [XLEN-1:0] w_exc_tval;
    logic            w_exc_to_s;
    logic            w_int_win;
    logic            w_ret;
    logic            w_to_s;
    logic            w_accept;
    logic [XLEN-1:0] w_tvec;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_int_cause;

    trap_int_prio #(.XLEN(XLEN)) u_prio (
        .i_mip         (mip),
        .i_mie         (mie),
        .i_mideleg     (mideleg),
        .i_cur_mode    (cur_mode),
        .i_mstatus_mie (mstatus_mie),
        .i_mstatus_sie (mstatus_sie),
        .o_valid       (w_irq_valid),
        .o_code        (w_irq_code),
        .o_to_s        (w_irq_to_s)
    );

    // MRET and SRET together is an illegal encoding, raised as a trap.
    assign w_ret_both = cmt_mret && cmt_sret;
    assign w_exc_any  = cmt_exc || w_ret_both;
    assign w_exc_code = cmt_exc ? cmt_ecode : EXC_ILLEGAL_INSN;
    assign w_exc_tval = cmt_exc ? cmt_tval : '0;
    assign w_exc_to_s = medeleg[w_exc_code] && (cur_mode != PRIV_M);

    assign w_int_win = w_irq_valid && (!w_exc_any || PRIO_INT_OVER_EXC);
    assign w_ret     = (cmt_mret ^ cmt_sret) && !w_exc_any && !w_irq_valid;
    assign w_to_s    = w_int_win ? w_irq_to_s : w_exc_to_s;
    assign w_accept  = rst_n && (r_state == ST_IDLE) && cmt_valid &&
                       (w_irq_valid || w_exc_any || w_ret);

    assign w_tvec = w_to_s ? stvec : mtvec;
    assign w_base = {w_tvec[XLEN-1:2], 2'b00};

    always_comb begin
        w_int_cause         = '0;
        w_int_cause[XLEN-1] = 1'b1;
        w_int_cause[4:0]    = w_irq_code;
    end

`ifdef TRAP_VECTORED_EN
    // Vectored mode only offsets interrupts; the add wraps at XLEN.
    assign w_trap_pc = (w_int_win && (w_tvec[1:0] == 2'b01)) ?
                       w_base + (XLEN'(w_irq_code) << 2) : w_base;
`else
    assign w_trap_pc = w_base;
`endif

    assign w_target = !w_ret  ? w_trap_pc :
                      cmt_mret ? mepc : sepc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_redir_pc <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_redir_pc <= w_target;
        end
    end

    always_comb begin
        w_next            = r_state;
        cmt_stall         = 1'b0;
        csr_we            = 1'b0;
        csr_kind          = KIND_TRAP_M;
        csr_cause         = '0;
        csr_epc           = '0;
        csr_tval          = '0;
        fetch.redir_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    csr_we    = 1'b1;
                    cmt_stall = 1'b1;
                    w_next    = ST_REDIR;
                    if (w_ret) begin
                        csr_kind = cmt_mret ? KIND_MRET : KIND_SRET;
                    end else begin
                        csr_kind  = w_to_s ? KIND_TRAP_S : KIND_TRAP_M;
                        csr_epc   = cmt_pc;
                        csr_cause = w_int_win ? w_int_cause
                                              : XLEN'(w_exc_code);
                        csr_tval  = w_int_win ? '0 : w_exc_tval;
                    end
                end
            end
            ST_REDIR: begin
                fetch.redir_valid = 1'b1;
                cmt_stall         = 1'b1;
                if (fetch.redir_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign fetch.redir_pc = r_redir_pc;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: two instances (interrupt-over-exception
// priority on and off) share stimulus; immediate assertions check each step.
module tb_trap_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmt_valid;
    logic [XLEN-1:0] cmt_pc;
    logic            cmt_exc;
    logic [4:0]      cmt_ecode;
    logic [XLEN-1:0] cmt_tval;
    logic            cmt_mret;
    logic            cmt_sret;
    logic [1:0]      cur_mode;
    logic            mstatus_mie;
    logic            mstatus_sie;
    logic [XLEN-1:0] mip, mie, medeleg, mideleg;
    logic [XLEN-1:0] mtvec, stvec, mepc, sepc;

    logic            stall1, we1, stall0, we0;
    logic [1:0]      kind1, kind0;
    logic [XLEN-1:0] cause1, epc1, tval1, cause0, epc0, tval0;

    int vectors = 0;
    int errors  = 0;

    trap_ctrl_if #(.XLEN(XLEN)) if1 ();
    trap_ctrl_if #(.XLEN(XLEN)) if0 ();

    trap_ctrl #(.XLEN(XLEN), .PRIO_INT_OVER_EXC(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_exc(cmt_exc),
        .cmt_ecode(cmt_ecode), .cmt_tval(cmt_tval),
        .cmt_mret(cmt_mret), .cmt_sret(cmt_sret),
        .cur_mode(cur_mode), .mstatus_mie(mstatus_mie),
        .mstatus_sie(mstatus_sie), .mip(mip), .mie(mie),
        .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec),
        .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .cmt_stall(stall1), .csr_we(we1), .csr_kind(kind1),
        .csr_cause(cause1), .csr_epc(epc1), .csr_tval(tval1),
        .fetch(if1)
    );

    trap_ctrl #(.XLEN(XLEN), .PRIO_INT_OVER_EXC(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_exc(cmt_exc),
        .cmt_ecode(cmt_ecode), .cmt_tval(cmt_tval),
        .cmt_mret(cmt_mret), .cmt_sret(cmt_sret),
        .cur_mode(cur_mode), .mstatus_mie(mstatus_mie),
        .mstatus_sie(mstatus_sie), .mip(mip), .mie(mie),
        .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec),
        .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .cmt_stall(stall0), .csr_we(we0), .csr_kind(kind0),
        .csr_cause(cause0), .csr_epc(epc0), .csr_tval(tval0),
        .fetch(if0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmt_valid = 1'b0;
        cmt_exc   = 1'b0;
        cmt_mret  = 1'b0;
        cmt_sret  = 1'b0;
        cmt_ecode = '0;
        cmt_tval  = '0;
        mip       = '0;
    endtask

    task automatic release_redir();
        if1.redir_ready = 1'b1;
        if0.redir_ready = 1'b1;
        tick();
        if1.redir_ready = 1'b0;
        if0.redir_ready = 1'b0;
    endtask

    initial begin
        logic [XLEN-1:0] vec_pc;
        rst_n = 1'b0;
        idle_inputs();
        cmt_pc = '0; cur_mode = 2'd3;
        mstatus_mie = 1'b0; mstatus_sie = 1'b0;
        mie = '0; medeleg = '0; mideleg = '0;
        mtvec = '0; stvec = '0; mepc = '0; sepc = '0;
        if1.redir_ready = 1'b0;
        if0.redir_ready = 1'b0;
        tick(); tick();

        chk("rst_stall", stall1, 0);
        chk("rst_we", we1, 0);
        chk("rst_rvalid", if1.redir_valid, 0);
        chk("rst_rpc", if1.redir_pc, 0);
        chk("rst_cause", cause1, 0);

        // Delegated exception from U mode to S.
        rst_n = 1'b1;
        cur_mode = 2'd0; medeleg = 32'h100; stvec = 32'h8000_0000;
        cmt_valid = 1'b1; cmt_exc = 1'b1; cmt_ecode = 5'd8;
        cmt_pc = 32'h100; cmt_tval = 32'h55;
        #1;
        chk("exc_we", we1, 1);
        chk("exc_kind", kind1, 1);
        chk("exc_cause", cause1, 8);
        chk("exc_epc", epc1, 32'h100);
        chk("exc_tval", tval1, 32'h55);
        chk("exc_stall", stall1, 1);
        chk("exc_rvalid_n", if1.redir_valid, 0);
        tick();
        idle_inputs();
        chk("exc_rvalid", if1.redir_valid, 1);
        chk("exc_rpc", if1.redir_pc, 32'h8000_0000);
        chk("exc_we_redir", we1, 0);
        release_redir();
        chk("exc_back_rvalid", if1.redir_valid, 0);
        chk("exc_back_stall", stall1, 0);

        // M-mode interrupt, MEI beats MTI.
        cur_mode = 2'd3; mstatus_mie = 1'b1; medeleg = '0;
        mip = 32'h880; mie = 32'h880; mideleg = '0; mtvec = 32'h201;
        cmt_valid = 1'b1; cmt_pc = 32'h300;
        #1;
        chk("irq_we", we1, 1);
        chk("irq_cause", cause1, 32'h8000_000B);
        chk("irq_kind", kind1, 0);
        chk("irq_epc", epc1, 32'h300);
        chk("irq_tval", tval1, 0);
        tick();
        idle_inputs();
`ifdef TRAP_VECTORED_EN
        vec_pc = 32'h22C;
`else
        vec_pc = 32'h200;
`endif
        chk("irq_rpc", if1.redir_pc, vec_pc);
        release_redir();

        // MRET.
        mepc = 32'h400; cmt_valid = 1'b1; cmt_mret = 1'b1;
        #1;
        chk("mret_we", we1, 1);
        chk("mret_kind", kind1, 2);
        tick();
        idle_inputs();
        chk("mret_rpc", if1.redir_pc, 32'h400);
        release_redir();

        // Delegated STI in M mode is not taken.
        mip = 32'h20; mie = 32'h20; mideleg = 32'h20; cmt_valid = 1'b1;
        #1;
        chk("sti_m_we", we1, 0);
        chk("sti_m_stall", stall1, 0);
        tick();
        chk("sti_m_rvalid", if1.redir_valid, 0);
        idle_inputs();

        // Delegated SEI from U mode goes to S.
        cur_mode = 2'd0; stvec = 32'h2000;
        mip = 32'h200; mie = 32'h200; mideleg = 32'h200; cmt_valid = 1'b1;
        #1;
        chk("sei_kind", kind1, 1);
        chk("sei_cause", cause1, 32'h8000_0009);
        tick();
        idle_inputs();
        chk("sei_rpc", if1.redir_pc, 32'h2000);
        release_redir();

        // Redirect held off; new events ignored.
        cur_mode = 2'd3; mideleg = '0; mtvec = 32'h1000;
        cmt_valid = 1'b1; cmt_exc = 1'b1; cmt_ecode = 5'd2; cmt_pc = 32'h50;
        tick();
        cmt_ecode = 5'd5; mtvec = 32'h3000;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid", if1.redir_valid, 1);
            chk("hold_stall", stall1, 1);
            chk("hold_we", we1, 0);
            chk("hold_rpc", if1.redir_pc, 32'h1000);
            tick();
        end
        idle_inputs();
        release_redir();
        chk("hold_rel_rvalid", if1.redir_valid, 0);
        chk("hold_rel_stall", stall1, 0);
        mtvec = 32'h1000;

        // Interrupt plus exception together.
        mip = 32'h8; mie = 32'h8; cmt_valid = 1'b1; cmt_pc = 32'h60;
        cmt_exc = 1'b1; cmt_ecode = 5'd4; cmt_tval = 32'hDEAD;
        #1;
        chk("sim_p1_cause", cause1, 32'h8000_0003);
        chk("sim_p1_tval", tval1, 0);
        chk("sim_p0_cause", cause0, 4);
        chk("sim_p0_tval", tval0, 32'hDEAD);
        chk("sim_p0_we", we0, 1);
        tick();
        idle_inputs();
        chk("sim_p1_rpc", if1.redir_pc, 32'h1000);
        chk("sim_p0_rpc", if0.redir_pc, 32'h1000);
        release_redir();

        // MRET+SRET together is an illegal instruction.
        cmt_valid = 1'b1; cmt_mret = 1'b1; cmt_sret = 1'b1; cmt_pc = 32'h70;
        #1;
        chk("both_kind", kind1, 0);
        chk("both_cause", cause1, 2);
        chk("both_tval", tval1, 0);
        chk("both_epc", epc1, 32'h70);
        tick();
        idle_inputs();
        chk("both_rpc", if1.redir_pc, 32'h1000);

        // Reset while in REDIR.
        chk("mid_rvalid", if1.redir_valid, 1);
        rst_n = 1'b0;
        cmt_valid = 1'b1; cmt_exc = 1'b1;
        tick();
        chk("rst2_rvalid", if1.redir_valid, 0);
        chk("rst2_stall", stall1, 0);
        chk("rst2_we", we1, 0);
        chk("rst2_rpc", if1.redir_pc, 0);
        chk("rst2_cause", cause1, 0);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        chk("rst2_idle", if1.redir_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Generating end of the trap-cause encoding: turns commit-stage exceptions, pending interrupts and xRET requests into cause values, target privilege, CSR update strobes and a fetch redirect.
- Sits between the commit stage, the CSR file (which owns mstatus/xepc/xcause/xtval storage) and the fetch unit.
- Serialises one trap or return at a time and holds commit stalled until fetch accepts the redirect.

Parameters:
- XLEN, 32: data/PC width; only 32 or 64 are legal.
- PRIO_INT_OVER_EXC, 1: when set, an interrupt pending in the same cycle as a commit exception wins. When clear, the exception wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- cmt_valid  in  1  commit stage presents an instruction
- cmt_pc  in  XLEN  PC of the committing instruction
- cmt_exc  in  1  committing instruction raised an exception
- cmt_ecode  in  5  exception code, using the shared cause constants 0..15
- cmt_tval  in  XLEN  trap value for the exception
- cmt_mret  in  1  committing instruction is MRET
- cmt_sret  in  1  committing instruction is SRET
- cur_mode  in  2  current privilege: 0=U, 1=S, 3=M
- mstatus_mie, mstatus_sie  in  1 each  global interrupt enables
- mip, mie  in  XLEN each  pending and enable bits
- medeleg, mideleg  in  XLEN each  delegation masks
- mtvec, stvec, mepc, sepc  in  XLEN each  CSR values
- cmt_stall  out  1  commit must hold its current instruction
- csr_we  out  1  one-cycle CSR update strobe
- csr_kind  out  2  0=TRAP_M, 1=TRAP_S, 2=MRET, 3=SRET
- csr_cause  out  XLEN  value written to xcause
- csr_epc  out  XLEN  value written to xepc
- csr_tval  out  XLEN  value written to xtval
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  XLEN  redirect target
- redir_ready  in  1  fetch accepts the redirect

Behaviour:
- States: IDLE, REDIR.
- Reset: state=IDLE. All outputs are 0, including cmt_stall, csr_we, redir_valid, redir_pc and csr_*.
- Interrupt selection, evaluated combinationally in IDLE:
  - p = mip & mie.
  - M-targeted set = p & ~mideleg. Enabled if cur_mode<3 or mstatus_mie.
  - S-targeted set = p & mideleg. Enabled if cur_mode<1, or (cur_mode==1 and mstatus_sie). Never enabled when cur_mode==3.
  - Priority order: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5). Any enabled M-targeted interrupt beats S-targeted ones.
  - The cause value sets the interrupt bit (MSB of XLEN) OR'd with the code.
- Interrupts are sampled only when cmt_valid=1, i.e. at an instruction boundary.
- IDLE, event accepted (cmt_valid plus one of: interrupt, exception or xRET) — same cycle:
  - csr_we=1, cmt_stall=1.
  - Interrupt: csr_epc=cmt_pc and csr_tval=0. The instruction is discarded.
  - Exception:
    - Target is S if medeleg[ecode]=1 and cur_mode<3; otherwise M.
    - csr_cause=ecode, csr_epc=cmt_pc, csr_tval=cmt_tval.
  - MRET: kind=2, redirect target = mepc.
  - SRET: kind=3, redirect target = sepc.
  - Trap redirect target = (xtvec & ~3).
  - redir_pc is registered. Next state = REDIR.
- Simultaneous events:
  - Interrupt and exception in the same cycle are resolved by PRIO_INT_OVER_EXC.
  - An exception on an xRET instruction takes priority over the return.
  - cmt_mret and cmt_sret both high is treated as an illegal-instruction trap (ecode 2, tval 0).
- REDIR:
  - redir_valid=1 and cmt_stall=1. redir_pc is held stable.
  - On redir_valid & redir_ready: return to IDLE. cmt_stall drops the following cycle.
  - No new event is accepted in REDIR; csr_we stays 0.
- Latency: an event in cycle N gives csr_we in N and redir_valid from N+1. The earliest possible next event is N+2.
- Reset mid-REDIR: the pending redirect is dropped and state returns to IDLE.
- Width: the code→cause mapping zero-extends. The vector offset (optional feature) is computed mod 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: if xtvec[1:0]==1 and the trap is an interrupt, redir_pc = (xtvec & ~3) + 4*code. Exceptions always go to the base address.
- Undefined: xtvec[1:0] is ignored and every trap goes to (xtvec & ~3).

Decomposition:
- Shared CSR package gains:
  - an interrupt-code enum {SSI=1, MSI=3, STI=5, MTI=7, SEI=9, MEI=11};
  - a csr_kind enum;
  - privilege constants PRIV_U=0, PRIV_S=1, PRIV_M=3.
- Cause constants and CSR addresses are used from the existing package.
- One sub-module, trap_int_prio: purely combinational priority/delegation selection. It outputs valid, code and target.

Test Plan:
- Exception routing: mode U, medeleg[8]=1, cmt_exc ecode=8 at pc 0x100, stvec=0x8000_0000 → csr_we with kind=1, cause=8, epc=0x100; then redir_pc=0x8000_0000.
- M-mode interrupt: mode M, mstatus_mie=1, mip=mie=0x880 (MTI+MEI), mideleg=0 → cause=0x8000_000B. With TRAP_VECTORED_EN and mtvec=0x201, redir_pc=0x22C.
- xRET and disabled interrupts: MRET with mepc=0x400 → kind=2, redir_pc=0x400. An STI pending in M mode with mideleg[5]=1 is not taken.
- Redirect handshake: redir_ready held low for 5 cycles → redir_valid and cmt_stall stay high, redir_pc is stable, and a new cmt_exc is ignored. Ready pulses → IDLE next cycle.
- Simultaneous events: interrupt plus exception in the same cycle with PRIO_INT_OVER_EXC=1 → interrupt cause with tval=0. With the parameter 0 → exception cause.
- Reset mid-operation: rst_n low while in REDIR → next cycle all outputs 0 and state IDLE.
